// File: rtl/vce_palette_gen.sv
// vce_palette_gen: video colour encoder. Maps VDC pixel indices to RGB via a
// CPU-programmable colour table (CRAM), with sync blanking, backdrop
// substitution, a prefetched CPU read buffer and selectable dot-clock dividers.
// Optional build macro: VCE_GRAYSCALE_EN (CR[7] selects luma output).
module vce_palette_gen #(
  parameter int CH_W   = 3,
  parameter int ADDR_W = 9,
  parameter int DIV0   = 4,
  parameter int DIV1   = 3,
  parameter int DIV2   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] VD,
  input  logic              HSYN,
  input  logic              VSYN,
  input  logic [2:0]        A,
  input  logic [7:0]        D_in,
  output logic [7:0]        D_out,
  output logic              D_oe,
  input  logic              RD_n,
  input  logic              WR_n,
  input  logic              CS_n,
  output logic [CH_W-1:0]   VIDEO_R,
  output logic [CH_W-1:0]   VIDEO_G,
  output logic [CH_W-1:0]   VIDEO_B,
  output logic              blank,
  output logic              clock_en
);
  localparam int E     = 3 * CH_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = 8;

  logic [7:0]        cr, ctw;
  logic [ADDR_W-1:0] cta, cta_lo_wr, cta_hi_wr;
  logic [E-1:0]      cbuf;
  logic              cta_chg;
  logic [CNT_W-1:0]  cnt, div;
  logic              prev_rd, prev_wr, arm_rd, arm_wr;
  logic              rd_act, wr_act, rd_ev, wr_ev;
  logic [7:0]        rd_hi;
  logic [E-1:0]      cram [DEPTH];
  logic              unused_ok;

  // ---------------- strobe edge detection ----------------
  // The arm flags stay low until a strobe has been seen idle after reset, so a
  // strobe already held across reset release never fires an event.
  assign rd_act = ~(RD_n | CS_n);
  assign wr_act = ~(WR_n | CS_n);
  assign wr_ev  = wr_act & prev_wr & arm_wr;
  assign rd_ev  = rd_act & prev_rd & arm_rd & ~wr_ev;  // write wins
  assign D_oe   = ~RD_n & ~CS_n;

  // Strobe history and arming
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_rd <= 1'b1;
      prev_wr <= 1'b1;
      arm_rd  <= 1'b0;
      arm_wr  <= 1'b0;
    end else begin
      prev_rd <= ~rd_act;
      prev_wr <= ~wr_act;
      arm_rd  <= arm_rd | ~rd_act;
      arm_wr  <= arm_wr | ~wr_act;
    end
  end

  // ---------------- dot clock ----------------
  // Divider selection from the dot mode bits
  always_comb begin
    case (cr[1:0])
      2'd0:    div = CNT_W'(DIV0);
      2'd1:    div = CNT_W'(DIV1);
      default: div = CNT_W'(DIV2);
    endcase
  end

  assign clock_en = (cnt == div - 1'b1);

  // Divider counter; a CR write restarts the period
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                 cnt <= '0;
    else if ((wr_ev && A == 3'd0) || clock_en) cnt <= '0;
    else                                       cnt <= cnt + 1'b1;
  end

  // ---------------- MMIO ----------------
  // Address-register update values and the upper read byte (unused bits read 1)
  always_comb begin
    cta_lo_wr = (cta & ~ADDR_W'(8'hFF)) | ADDR_W'(D_in);
    cta_hi_wr = ADDR_W'({D_in, cta[7:0]});
    rd_hi     = 8'({8'hFF, cbuf} >> 8);
  end

  // Control registers, table address and read prefetch
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cr      <= '0;
      ctw     <= '0;
      cta     <= '0;
      cbuf    <= '0;
      cta_chg <= 1'b0;
    end else begin
      cta_chg <= 1'b0;
      if (cta_chg) cbuf <= cram[cta];
      if (wr_ev) begin
        case (A)
          3'd0: cr <= D_in;
          3'd2: begin cta <= cta_lo_wr; cta_chg <= 1'b1; end
          3'd3: if (ADDR_W > 8) begin cta <= cta_hi_wr; cta_chg <= 1'b1; end
          3'd4: ctw <= D_in;
          3'd5: begin cta <= cta + 1'b1; cta_chg <= 1'b1; end
          default: ;
        endcase
      end else if (rd_ev && A == 3'd5) begin
        cta     <= cta + 1'b1;
        cta_chg <= 1'b1;
      end
    end
  end

  // Colour table write port (contents survive reset)
  always_ff @(posedge clock) begin
    if (wr_ev && A == 3'd5) cram[cta] <= {D_in[E-9:0], ctw};
  end

  // CPU read data mux
  always_comb begin
    case (A)
      3'd4:    D_out = cbuf[7:0];
      3'd5:    D_out = rd_hi;
      default: D_out = 8'hFF;
    endcase
  end

  // ---------------- pixel pipeline ----------------
  logic [ADDR_W-1:0] s1_idx;
  logic              blank_s1;
  logic [E-1:0]      px;
  logic [CH_W-1:0]   px_r, px_g, px_b, o_r, o_g, o_b;

  // Video read sees pre-write data on a same-cycle CPU write (NBA ordering)
  assign px   = cram[s1_idx];
  assign px_b = px[CH_W-1:0];
  assign px_r = px[2*CH_W-1:CH_W];
  assign px_g = px[E-1:2*CH_W];

`ifdef VCE_GRAYSCALE_EN
  logic [11:0] luma_sum, luma;
  assign luma_sum  = 12'(px_r) * 12'd3 + 12'(px_g) * 12'd6 + 12'(px_b) + 12'd5;
  assign luma      = luma_sum / 12'd10;
  assign o_r       = cr[7] ? luma[CH_W-1:0] : px_r;
  assign o_g       = cr[7] ? luma[CH_W-1:0] : px_g;
  assign o_b       = cr[7] ? luma[CH_W-1:0] : px_b;
  assign unused_ok = ^{cr[6:2], luma[11:CH_W]};
`else
  assign o_r       = px_r;
  assign o_g       = px_g;
  assign o_b       = px_b;
  assign unused_ok = ^cr[7:2];
`endif

  // Two-stage pixel pipe advancing on the dot clock enable
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_idx   <= '0;
      blank_s1 <= 1'b1;
      VIDEO_R  <= '0;
      VIDEO_G  <= '0;
      VIDEO_B  <= '0;
      blank    <= 1'b1;
    end else if (clock_en) begin
      s1_idx   <= (VD[3:0] == 4'd0) ? '0 : VD;  // backdrop substitution
      blank_s1 <= ~HSYN | ~VSYN;
      if (blank_s1) begin
        VIDEO_R <= '0;
        VIDEO_G <= '0;
        VIDEO_B <= '0;
        blank   <= 1'b1;
      end else begin
        VIDEO_R <= o_r;
        VIDEO_G <= o_g;
        VIDEO_B <= o_b;
        blank   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vce_palette_gen.sv
// Self-checking bench for vce_palette_gen: dot-clock table, MMIO table access
// and pixel vector tables, with expected CPU reads and pixels queued in a
// scoreboard as stimulus is driven.
module tb_vce_palette_gen;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] VD;
  logic       HSYN, VSYN;
  logic [2:0] A;
  logic [7:0] D_in, D_out;
  logic       D_oe, RD_n, WR_n, CS_n;
  logic [2:0] VIDEO_R, VIDEO_G, VIDEO_B;
  logic       blank, clock_en;

  always #5 clock = ~clock;

  vce_palette_gen #(.CH_W(3), .ADDR_W(9), .DIV0(4), .DIV1(3), .DIV2(2)) dut (
    .clock(clock), .reset(reset), .VD(VD), .HSYN(HSYN), .VSYN(VSYN),
    .A(A), .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
    .RD_n(RD_n), .WR_n(WR_n), .CS_n(CS_n),
    .VIDEO_R(VIDEO_R), .VIDEO_G(VIDEO_G), .VIDEO_B(VIDEO_B),
    .blank(blank), .clock_en(clock_en)
  );

  typedef struct { string name; logic [31:0] exp; } sb_t;
  typedef struct { logic [8:0] vd; logic h; logic v; logic [9:0] exp; } pv_t;
  typedef struct { logic [7:0] cr; int first; int period; } dv_t;

  sb_t sbq[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sb_check(input logic [31:0] act);
    sb_t e;
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: output %0h with no expectation queued", act);
    end else begin
      e = sbq.pop_front();
      chk(e.name, act, e.exp);
    end
  endtask

  task automatic count_to_pulse(output int p);
    p = 0;
    do begin @(negedge clock); p++; end while (!clock_en && p < 40);
  endtask

  task automatic wait_pulse();
    int k;
    count_to_pulse(k);
    if (!clock_en) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_pulse: no clock_en within %0d cycles", k);
    end
  endtask

  task automatic mmio_wr(input logic [2:0] a, input logic [7:0] d);
    A = a; D_in = d; CS_n = 1'b0; WR_n = 1'b0;
    @(negedge clock);
    WR_n = 1'b1; CS_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic mmio_rd(input logic [2:0] a, input logic [7:0] e, input string nm);
    A = a; CS_n = 1'b0; RD_n = 1'b0;
    sbq.push_back('{nm, 32'(e)});
    @(negedge clock);
    chk({nm, "_oe"}, 32'(D_oe), 32'd1);
    sb_check(32'(D_out));
    RD_n = 1'b1; CS_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic cram_wr(input logic [8:0] addr, input logic [8:0] val);
    mmio_wr(3'd2, addr[7:0]);
    mmio_wr(3'd3, {7'b0, addr[8]});
    mmio_wr(3'd4, val[7:0]);
    mmio_wr(3'd5, {7'b0, val[8]});
  endtask

  task automatic pix(input string nm, input pv_t v);
    VD = v.vd; HSYN = v.h; VSYN = v.v;
    sbq.push_back('{nm, 32'(v.exp)});
    wait_pulse();
    wait_pulse();
    @(negedge clock);
    sb_check(32'({blank, VIDEO_G, VIDEO_R, VIDEO_B}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pv_t pvt[8];
    pv_t gvt[3];
    dv_t dvt[4];
    int  p;

    // expected {blank, G, R, B}
    pvt[0] = '{9'h023, 1'b1, 1'b1, 10'b0_111_000_111};
    pvt[1] = '{9'h020, 1'b1, 1'b1, 10'b0_010_100_101};  // backdrop
    pvt[2] = '{9'h1F1, 1'b1, 1'b1, 10'b0_000_111_000};
    pvt[3] = '{9'h145, 1'b1, 1'b1, 10'b0_101_010_010};
    pvt[4] = '{9'h023, 1'b0, 1'b1, 10'b1_000_000_000};  // HSYN blank
    pvt[5] = '{9'h023, 1'b1, 1'b0, 10'b1_000_000_000};  // VSYN blank
    pvt[6] = '{9'h100, 1'b1, 1'b1, 10'b0_010_100_101};  // backdrop
    pvt[7] = '{9'h023, 1'b1, 1'b1, 10'b0_111_000_111};  // restored
`ifdef VCE_GRAYSCALE_EN
    gvt[0] = '{9'h1F1, 1'b1, 1'b1, 10'b0_010_010_010};
    gvt[2] = '{9'h145, 1'b1, 1'b1, 10'b0_100_100_100};
`else
    gvt[0] = '{9'h1F1, 1'b1, 1'b1, 10'b0_000_111_000};
    gvt[2] = '{9'h145, 1'b1, 1'b1, 10'b0_101_010_010};
`endif
    gvt[1] = '{9'h0EF, 1'b1, 1'b1, 10'b0_111_111_111};
    dvt[0] = '{8'h01, 3, 3};
    dvt[1] = '{8'h02, 2, 2};
    dvt[2] = '{8'h03, 2, 2};
    dvt[3] = '{8'h00, 4, 4};

    // reset with a CR write strobe held across release
    VD = '0; HSYN = 1'b1; VSYN = 1'b1; A = 3'd4; D_in = 8'h01;
    RD_n = 1'b1; WR_n = 1'b0; CS_n = 1'b0;
    @(negedge clock); @(negedge clock);
    chk("rst_pixel", 32'({blank, VIDEO_G, VIDEO_R, VIDEO_B}), 32'h200);
    chk("rst_clock_en", 32'(clock_en), 32'd0);
    chk("rst_d_oe", 32'(D_oe), 32'd0);
    chk("rst_dout_a4", 32'(D_out), 32'h00);
    A = 3'd5; #1;
    chk("rst_dout_a5", 32'(D_out), 32'hFE);
    A = 3'd0;
    @(negedge clock); reset = 1'b0;
    repeat (3) @(negedge clock);
    WR_n = 1'b1; CS_n = 1'b1;
    count_to_pulse(p);
    count_to_pulse(p);
    chk("rst_midstrobe_period", 32'(p), 32'd4);

    // dot clock modes
    foreach (dvt[i]) begin
      A = 3'd0; D_in = dvt[i].cr; CS_n = 1'b0; WR_n = 1'b0; p = 0;
      do begin
        @(negedge clock); p++;
        if (p == 1) begin WR_n = 1'b1; CS_n = 1'b1; end
      end while (!clock_en && p < 40);
      chk($sformatf("div_first_cr%0d", dvt[i].cr), 32'(p), 32'(dvt[i].first));
      count_to_pulse(p);
      chk($sformatf("div_period_cr%0d", dvt[i].cr), 32'(p), 32'(dvt[i].period));
    end

    // table programming; the last write wraps CTA to 0
    cram_wr(9'h000, 9'h0A5);
    cram_wr(9'h023, 9'h1C7);
    cram_wr(9'h1F1, 9'h038);
    cram_wr(9'h145, 9'h152);
    cram_wr(9'h0EF, 9'h1FF);
    cram_wr(9'h051, 9'h044);
    cram_wr(9'h052, 9'h0EE);
    cram_wr(9'h061, 9'h011);
    cram_wr(9'h1FF, 9'h1AA);
    mmio_rd(3'd4, 8'hA5, "wrap_cta_to_0");
    mmio_wr(3'd2, 8'hFF);
    mmio_wr(3'd3, 8'h01);
    mmio_rd(3'd4, 8'hAA, "rd_1ff_a4");
    mmio_rd(3'd5, 8'hFF, "rd_1ff_a5");
    mmio_rd(3'd4, 8'hA5, "rd_wrap_a4");
    mmio_rd(3'd5, 8'hFE, "rd_wrap_a5");
    mmio_rd(3'd1, 8'hFF, "rd_other_addr");

    // 20-clock write strobe: one write, one increment
    mmio_wr(3'd2, 8'h50);
    mmio_wr(3'd3, 8'h00);
    mmio_wr(3'd4, 8'h33);
    A = 3'd5; D_in = 8'h01; CS_n = 1'b0; WR_n = 1'b0;
    repeat (20) @(negedge clock);
    WR_n = 1'b1; CS_n = 1'b1;
    @(negedge clock); @(negedge clock);
    mmio_rd(3'd4, 8'h44, "long_wr_one_incr");
    mmio_wr(3'd2, 8'h50);
    mmio_rd(3'd4, 8'h33, "long_wr_data_lo");
    mmio_rd(3'd5, 8'hFF, "long_wr_data_hi");

    // simultaneous read and write: write wins
    mmio_wr(3'd2, 8'h60);
    mmio_wr(3'd4, 8'h22);
    A = 3'd5; D_in = 8'h00; CS_n = 1'b0; WR_n = 1'b0; RD_n = 1'b0;
    @(negedge clock);
    RD_n = 1'b1; WR_n = 1'b1; CS_n = 1'b1;
    @(negedge clock); @(negedge clock);
    mmio_rd(3'd4, 8'h11, "rdwr_one_incr");
    mmio_wr(3'd2, 8'h60);
    mmio_rd(3'd4, 8'h22, "rdwr_write_lo");
    mmio_rd(3'd5, 8'hFE, "rdwr_write_hi");

    // pixel path
    foreach (pvt[i]) pix($sformatf("pix%0d_vd%0h", i, pvt[i].vd), pvt[i]);

    // CR[7] luma mode (ignored in the default build)
    mmio_wr(3'd0, 8'h80);
    foreach (gvt[i]) pix($sformatf("gray%0d_vd%0h", i, gvt[i].vd), gvt[i]);
    mmio_wr(3'd0, 8'h00);

    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vce_palette_gen.md
Name: vce_palette_gen

Overview:
- Parametrised next-generation video colour encoder. It converts VDC pixel indices into RGB through a CPU-programmable colour table (CRAM).
- Sits between the VDC pixel bus and the VGA output subsystem. It also sits on the CPU MMIO bus.
- Additions over the first-generation VCE:
  - configurable channel depth, table depth and dot-clock dividers;
  - sync blanking;
  - backdrop substitution;
  - a prefetched read buffer;
  - full-clock-rate edge detection.

Parameters:
- CH_W, 3, bits per colour channel. Legal range 3..5. Entry width E = 3*CH_W, so 9..15.
- ADDR_W, 9, colour-table address width. Legal range 8..16. Depth = 2^ADDR_W.
- DIV0, 4, master-clock divider for dot mode 0.
- DIV1, 3, divider for dot mode 1.
- DIV2, 2, divider for dot modes 2 and 3.

Ports:
- clock  in  1  master clock.
- reset  in  1  asynchronous active-high reset.
- VD  in  ADDR_W  pixel index from VDC.
- HSYN  in  1  horizontal sync from VDC, active low.
- VSYN  in  1  vertical sync from VDC, active low.
- A  in  3  MMIO register address.
- D_in  in  8  CPU write data.
- D_out  out  8  CPU read data.
- D_oe  out  1  read-data drive enable. Equals ~RD_n & ~CS_n.
- RD_n  in  1  CPU read strobe, active low.
- WR_n  in  1  CPU write strobe, active low.
- CS_n  in  1  chip select, active low.
- VIDEO_R  out  CH_W  red output.
- VIDEO_G  out  CH_W  green output.
- VIDEO_B  out  CH_W  blue output.
- blank  out  1  high while the output is blanked.
- clock_en  out  1  pixel clock enable, 1-cycle pulse.

Behaviour:
- Reset (asynchronous, active-high):
  - CR=0, CTA=0, CTW=0, CBUF=0, divider count=0.
  - VIDEO_R/G/B=0, blank=1, clock_en=0.
  - Edge-detect history set to 1 (idle). CRAM contents are not reset.
- Dot clock:
  - The divider count runs on every clock. clock_en=1 when count==DIV-1, and count then wraps to 0.
  - DIV is chosen by CR[1:0]: 0→DIV0, 1→DIV1, 2 or 3→DIV2.
  - A write to CR forces count=0 on the next cycle.
- Strobe detection:
  - Sampled every clock.
  - read event = ~(RD_n|CS_n) & prev_rd.
  - write event = ~(WR_n|CS_n) & prev_wr.
  - Exactly one event per strobe assertion, regardless of strobe length.
- MMIO writes:
  - A=0: CR <= D_in.
  - A=2: CTA[7:0] <= D_in.
  - A=3: CTA[ADDR_W-1:8] <= D_in[ADDR_W-9:0]. Ignored when ADDR_W=8.
  - A=4: CTW <= D_in.
  - A=5: CRAM[CTA] <= {D_in[E-9:0], CTW}, then CTA <= CTA+1.
  - Other addresses: no effect.
- MMIO reads:
  - A=4 returns CBUF[7:0].
  - A=5 returns {1s in the unused upper bits, CBUF[E-1:8]}, then CTA <= CTA+1.
  - All other addresses return 8'hFF.
- CTA wrap: increments wrap from 2^ADDR_W-1 to 0.
- Read prefetch:
  - The cycle after any change to CTA (write to A=2, A=3, or an increment), CBUF <= CRAM[CTA].
  - This includes the cycle after an A=5 write, so CBUF holds the new data when CTA aliases the written entry.
  - D_out is combinational from CBUF. It is stable no later than 2 clocks after the event.
- Pixel pipeline, two stages, both advancing only on clock_en:
  - Stage 1 captures the index (VD, with VD[3:0]==0 mapped to backdrop entry 0) and blank_s1 = ~HSYN | ~VSYN.
  - Stage 2 reads CRAM and registers the outputs. When blank_s1=1, the outputs are 0 and blank=1.
  - Latency: the pixel sampled at clock_en pulse k appears after pulse k+1.
  - Colour mapping: VIDEO_B = entry[CH_W-1:0], VIDEO_R = entry[2CH_W-1:CH_W], VIDEO_G = entry[E-1:2CH_W].
- Collision: a CPU write and a video read of the same entry in the same cycle return old data to the video path (read-before-write). The write still commits.
- Simultaneous read and write events: the write wins and the read is dropped.
- Reset mid-strobe: no event fires until the strobe deasserts and reasserts.

Optional Feature:
- Macro: VCE_GRAYSCALE_EN.
- When defined: CR[7]=1 replaces each channel with luma Y = (R*3 + G*6 + B*1 + 5)/10, truncated to CH_W bits. This is applied in stage 2 and adds no latency.
- When undefined: CR[7] is stored but ignored, and the luma logic is absent.

Test Plan:
- Reset, then CR=0 → clock_en pulses every 4 clocks. Writing CR=1 gives a period of 3; CR=2 or 3 gives a period of 2. The first pulse after the CR write comes DIV clocks later.
- Write CTA=0x1FF, CTW=0xAA, A5=0x01 → CRAM[0x1FF]=0x1AA, and CTA wraps to 0. Then reading A4 then A5 at CTA=0x1FF returns 0xAA, then 0xFF (bit0=1).
- Hold WR_n low for 20 clocks on A=5 → exactly one CRAM write and exactly one CTA increment.
- Write CRAM[0x023]=0x1C7, drive VD=0x023 with syncs high → after the second clock_en, G=7, R=0, B=7, blank=0. With VD=0x020 → outputs equal entry 0.
- Drive HSYN=0 → after 2 clock_en pulses, RGB=0 and blank=1. Releasing HSYN restores the pixel 2 pulses later.
- With VCE_GRAYSCALE_EN, CR=0x80, entry=0x1FF → all channels=7. Entry R=7 only (0x038) → all channels=2.
